// File: rtl/bird_pkg.sv
// rtl/bird_pkg.sv - shared types and default constants for the bird motion datapath
package bird_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        LANDED = 2'd3
    } motion_state_t;

    localparam int BIRD_TICK_DIV  = 833333;  // 50 MHz / 60 Hz
    localparam int BIRD_UP_TICKS  = 12;
    localparam int BIRD_Y_W       = 10;
    localparam int BIRD_Y_TOP     = 0;
    localparam int BIRD_Y_GROUND  = 460;
    localparam int BIRD_Y_START   = 240;
    localparam int BIRD_RISE_STEP = 4;
    localparam int BIRD_VMAX      = 6;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - frame tick prescaler; BIRD_FAST_SIM_EN makes every cycle a tick
module tick_gen
    import bird_pkg::*;
#(
    parameter int TICK_DIV = BIRD_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(TICK_DIV - 1));

    // The prescaler keeps running through freeze so tick phase is never disturbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
`ifdef BIRD_FAST_SIM_EN
            tick <= 1'b1;
`else
            tick <= wrap;
`endif
        end
    end

endmodule

// File: rtl/bird_motion_timer.sv
// rtl/bird_motion_timer.sv - flap timer and vertical motion FSM (BIRD_FAST_SIM_EN: tick every clk)
module bird_motion_timer
    import bird_pkg::*;
#(
    parameter int TICK_DIV  = BIRD_TICK_DIV,
    parameter int UP_TICKS  = BIRD_UP_TICKS,
    parameter int Y_W       = BIRD_Y_W,
    parameter int Y_TOP     = BIRD_Y_TOP,
    parameter int Y_GROUND  = BIRD_Y_GROUND,
    parameter int Y_START   = BIRD_Y_START,
    parameter int RISE_STEP = BIRD_RISE_STEP,
    parameter int VMAX      = BIRD_VMAX
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_counter,
    input  logic           en_subiendo,
    input  logic           freeze,
    output logic           frame_tick,
    output logic           time_out,
    output logic [Y_W-1:0] bird_y,
    output logic           hit_top,
    output logic           hit_ground
);

    localparam int CNT_W = (UP_TICKS > 1) ? $clog2(UP_TICKS) : 1;
    localparam int V_W   = $clog2(VMAX + 1);

    localparam logic [Y_W-1:0] TOP_V    = Y_W'(Y_TOP);
    localparam logic [Y_W-1:0] GROUND_V = Y_W'(Y_GROUND);
    localparam logic [Y_W-1:0] START_V  = Y_W'(Y_START);
    localparam logic [Y_W-1:0] STEP_V   = Y_W'(RISE_STEP);
    localparam logic [Y_W:0]   RISE_LIM = (Y_W+1)'(Y_TOP + RISE_STEP);
    localparam logic [Y_W:0]   GROUND_W = (Y_W+1)'(Y_GROUND);
    localparam logic [V_W-1:0] VMAX_V   = V_W'(VMAX);

    motion_state_t  state, state_nxt;
    logic [CNT_W-1:0] flap_cnt;
    logic [V_W-1:0] v, v_nxt;
    logic [Y_W-1:0] y_nxt;
    logic [Y_W:0]   sum;
    logic           land_nxt;
    logic           tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick)
    );

    assign tick = frame_tick & ~freeze;
    assign sum  = {1'b0, bird_y} + (Y_W+1)'(v);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flap_cnt <= '0;
            time_out <= 1'b0;
        end else begin
            time_out <= 1'b0;
            if (!en_counter) begin
                flap_cnt <= '0;
            end else if (tick) begin
                if (flap_cnt == CNT_W'(UP_TICKS - 1)) begin
                    flap_cnt <= '0;
                    time_out <= 1'b1;
                end else begin
                    flap_cnt <= flap_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Direction changes take the tick by themselves; the bird moves on the next tick.
    always_comb begin
        state_nxt = state;
        y_nxt     = bird_y;
        v_nxt     = v;
        land_nxt  = hit_ground;
        if (tick) begin
            case (state)
                HOLD: if (en_subiendo) state_nxt = RISE;
                RISE: begin
                    v_nxt = '0;
                    if (!en_subiendo)
                        state_nxt = FALL;
                    else if ({1'b0, bird_y} < RISE_LIM)
                        y_nxt = TOP_V;
                    else
                        y_nxt = bird_y - STEP_V;
                end
                FALL: begin
                    if (en_subiendo) begin
                        state_nxt = RISE;
                    end else if (sum >= GROUND_W) begin
                        y_nxt     = GROUND_V;
                        land_nxt  = 1'b1;
                        state_nxt = LANDED;
                    end else begin
                        y_nxt = sum[Y_W-1:0];
                        v_nxt = (v == VMAX_V) ? v : v + V_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HOLD;
            bird_y     <= START_V;
            v          <= '0;
            hit_top    <= 1'b0;
            hit_ground <= 1'b0;
        end else begin
            state      <= state_nxt;
            bird_y     <= y_nxt;
            v          <= v_nxt;
            hit_top    <= (y_nxt == TOP_V);
            hit_ground <= land_nxt;
        end
    end

endmodule

// File: tb/tb_bird_motion_timer.sv
// tb/tb_bird_motion_timer.sv - randomized bench against a behavioural bird motion model
module tb_bird_motion_timer;

`ifdef BIRD_FAST_SIM_EN
    localparam int D = 1;
`else
    localparam int D = 8;
`endif
    localparam int UP = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_counter = 1'b0;
    logic       en_subiendo = 1'b0;
    logic       freeze = 1'b0;
    logic       frame_tick;
    logic       time_out;
    logic [9:0] bird_y;
    logic       hit_top;
    logic       hit_ground;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers, updated once per clock edge.
    int  k, cnt_m, y_m, v_m;
    bit  tick_m, to_m, top_m, ground_m;
    bit  rising, falling, landed;

    bird_motion_timer #(.TICK_DIV(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_counter  (en_counter),
        .en_subiendo (en_subiendo),
        .freeze      (freeze),
        .frame_tick  (frame_tick),
        .time_out    (time_out),
        .bird_y      (bird_y),
        .hit_top     (hit_top),
        .hit_ground  (hit_ground)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    task automatic model_reset();
        k = 0; cnt_m = 0; y_m = 240; v_m = 0;
        tick_m = 0; to_m = 0; top_m = 0; ground_m = 0;
        rising = 0; falling = 0; landed = 0;
    endtask

    task automatic model_step();
        bit eff;
        k++;
        eff  = tick_m && !freeze;
        to_m = eff && en_counter && (cnt_m == UP - 1);
        if (!en_counter)
            cnt_m = 0;
        else if (eff)
            cnt_m = (cnt_m + 1) % UP;
        if (eff && !landed) begin
            if (rising) begin
                v_m = 0;
                if (!en_subiendo) begin
                    rising = 0; falling = 1;
                end else begin
                    y_m = (y_m - 4 < 0) ? 0 : y_m - 4;
                end
            end else if (falling) begin
                if (en_subiendo) begin
                    falling = 0; rising = 1;
                end else if (y_m + v_m >= 460) begin
                    y_m = 460; ground_m = 1; landed = 1; falling = 0;
                end else begin
                    y_m = y_m + v_m;
                    v_m = (v_m + 1 > 6) ? 6 : v_m + 1;
                end
            end else if (en_subiendo) begin
                rising = 1;
            end
        end
        top_m  = (y_m == 0);
        tick_m = (k % D) == 0;
    endtask

    task automatic compare_all(input string when);
        check({when, " frame_tick"}, int'(frame_tick), int'(tick_m));
        check({when, " time_out"},   int'(time_out),   int'(to_m));
        check({when, " bird_y"},     int'(bird_y),     y_m);
        check({when, " hit_top"},    int'(hit_top),    int'(top_m));
        check({when, " hit_ground"}, int'(hit_ground), int'(ground_m));
    endtask

    task automatic run(input int n, input bit ec, input bit es, input bit fz);
        for (int i = 0; i < n; i++) begin
            en_counter  = ec;
            en_subiendo = es;
            freeze      = fz;
            @(posedge clk);
            model_step();
            #1;
            compare_all("run");
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        run(4, 0, 0, 0);
        run(30 * D, 1, 0, 0);        // two flap time_outs
        run(70 * D, 1, 1, 0);        // rise into the ceiling
        run(5 * D, 1, 0, 0);
        run(10 * D, 1, 0, 1);        // freeze while falling
        run(100 * D, 1, 0, 0);       // land
        run(10 * D, 1, 1, 0);        // rise ignored once landed

        do_reset();
        run(8 * D + 2, 1, 1, 0);     // mid-flap, mid-rise
        do_reset();
        run(20 * D, 0, 0, 0);        // no trailing time_out

        run(5 * D, 1, 1, 0);
        run(20 * D, 1, 1, 1);        // freeze mid-flap
        run(10 * D, 1, 1, 0);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 24) == 0) do_reset();
            run($urandom_range(1, 3 * D), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1, ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
